// File: rtl/vx_mem_perf_collector_pkg.sv
// Shared constants and helpers for the memory-side performance collector.
// Counter width defaults to the core-wide performance counter width of 44 bits.
package vx_mem_perf_collector_pkg;

  localparam int PERF_CTR_BITS_DEFAULT = 44;

  localparam int LSU_LANES_DEFAULT    = 4;
  localparam int PENDING_BITS_DEFAULT = 8;

  // Lane vectors are widened to 32 bits before counting, so up to 32 lanes fit.
  localparam int POP_IN_W = 32;
  localparam int POP_W    = 6;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_IN_W-1:0] bits);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      cnt = cnt + POP_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_mem_perf_collector_pending_acc.sv
// Outstanding-transaction tracker with clamping, sticky error flag, and
// latency accumulator that sums the registered pending count every enabled cycle.
module VX_perf_pending_acc
  import vx_mem_perf_collector_pkg::*;
#(
  parameter int LANES        = 1,
  parameter int PENDING_BITS = 8,
  parameter int CTR_BITS     = 44,
  parameter bit ASSERT_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_perf_en,
  input  logic [LANES-1:0]    i_req,
  input  logic [LANES-1:0]    i_rsp,
  output logic [CTR_BITS-1:0] o_latency,
  output logic                o_err
);

  // Two guard bits keep the signed sum exact for any lane count up to 32.
  localparam int SUM_W = PENDING_BITS + POP_W + 2;

  logic [PENDING_BITS-1:0] r_pending;
  logic [CTR_BITS-1:0]     r_latency;
  logic                    r_err;

  logic [POP_W-1:0]        w_req_cnt;
  logic [POP_W-1:0]        w_rsp_cnt;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_max;
  logic                    w_under;
  logic                    w_over;
  logic [PENDING_BITS-1:0] w_pending_nxt;

  always_comb begin
    w_req_cnt = popcount(POP_IN_W'(i_req));
    w_rsp_cnt = popcount(POP_IN_W'(i_rsp));
    w_max     = $signed(SUM_W'({PENDING_BITS{1'b1}}));
    w_sum     = $signed(SUM_W'(r_pending)) + $signed(SUM_W'(w_req_cnt))
              - $signed(SUM_W'(w_rsp_cnt));
    w_under   = (w_sum < 0);
    w_over    = (w_sum > w_max);
    if (w_under) begin
      w_pending_nxt = '0;
    end else if (w_over) begin
      w_pending_nxt = '1;
    end else begin
      w_pending_nxt = w_sum[PENDING_BITS-1:0];
    end
  end

  // The tracker runs regardless of the enable; only the accumulation is gated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_latency <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_under || w_over) begin
        r_err <= 1'b1;
      end
      if (i_perf_en) begin
        r_latency <= r_latency + CTR_BITS'(r_pending);
      end
    end
  end

  always @(posedge clk) begin
    if (ASSERT_EN && reset_n) begin
      assert (!(w_under || w_over));
    end
  end

  assign o_latency = r_latency;
  assign o_err     = r_err;

endmodule

// File: rtl/vx_mem_perf_collector.sv
// Memory-side performance counters: fetch/load/store event counts plus
// fetch and load latency sums fed by two outstanding-request trackers.
module vx_mem_perf_collector
  import vx_mem_perf_collector_pkg::*;
#(
  parameter int PERF_CTR_BITS = PERF_CTR_BITS_DEFAULT,
  parameter int LSU_LANES     = LSU_LANES_DEFAULT,
  parameter int PENDING_BITS  = PENDING_BITS_DEFAULT,
  parameter bit ASSERT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     perf_en,
  input  logic                     ifetch_req_fire,
  input  logic                     ifetch_rsp_fire,
  input  logic [LSU_LANES-1:0]     ld_req_fire,
  input  logic [LSU_LANES-1:0]     st_req_fire,
  input  logic [LSU_LANES-1:0]     ld_rsp_fire,
  output logic [PERF_CTR_BITS-1:0] ifetches,
  output logic [PERF_CTR_BITS-1:0] loads,
  output logic [PERF_CTR_BITS-1:0] stores,
  output logic [PERF_CTR_BITS-1:0] ifetch_latency,
  output logic [PERF_CTR_BITS-1:0] load_latency,
  output logic                     pending_err
);

  logic [PERF_CTR_BITS-1:0] r_ifetches;
  logic [PERF_CTR_BITS-1:0] r_loads;
  logic [PERF_CTR_BITS-1:0] r_stores;

  logic [POP_W-1:0] w_ld_cnt;
  logic [POP_W-1:0] w_st_cnt;
  logic             w_ifetch_err;
  logic             w_load_err;

  always_comb begin
    w_ld_cnt = popcount(POP_IN_W'(ld_req_fire));
    w_st_cnt = popcount(POP_IN_W'(st_req_fire));
  end

  // Event counters wrap naturally at the counter width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ifetches <= '0;
      r_loads    <= '0;
      r_stores   <= '0;
    end else if (perf_en) begin
      r_ifetches <= r_ifetches + PERF_CTR_BITS'(ifetch_req_fire);
      r_loads    <= r_loads + PERF_CTR_BITS'(w_ld_cnt);
      r_stores   <= r_stores + PERF_CTR_BITS'(w_st_cnt);
    end
  end

  VX_perf_pending_acc #(
    .LANES        (1),
    .PENDING_BITS (PENDING_BITS),
    .CTR_BITS     (PERF_CTR_BITS),
    .ASSERT_EN    (ASSERT_EN)
  ) u_ifetch_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_perf_en (perf_en),
    .i_req     (ifetch_req_fire),
    .i_rsp     (ifetch_rsp_fire),
    .o_latency (ifetch_latency),
    .o_err     (w_ifetch_err)
  );

  VX_perf_pending_acc #(
    .LANES        (LSU_LANES),
    .PENDING_BITS (PENDING_BITS),
    .CTR_BITS     (PERF_CTR_BITS),
    .ASSERT_EN    (ASSERT_EN)
  ) u_load_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_perf_en (perf_en),
    .i_req     (ld_req_fire),
    .i_rsp     (ld_rsp_fire),
    .o_latency (load_latency),
    .o_err     (w_load_err)
  );

  assign ifetches    = r_ifetches;
  assign loads       = r_loads;
  assign stores      = r_stores;
  assign pending_err = w_ifetch_err | w_load_err;

endmodule

// File: tb/tb_vx_mem_perf_collector.sv
// Scoreboard bench for vx_mem_perf_collector: directed scenarios plus random traffic,
// checked against a counting model of outstanding requests and accumulated sums.
module tb_vx_mem_perf_collector;

  localparam int CTR_W    = 8;
  localparam int LANES    = 4;
  localparam int PEND_W   = 4;
  localparam int CTR_MOD  = 1 << CTR_W;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             perf_en;
  logic             ifetch_req_fire;
  logic             ifetch_rsp_fire;
  logic [LANES-1:0] ld_req_fire;
  logic [LANES-1:0] st_req_fire;
  logic [LANES-1:0] ld_rsp_fire;
  logic [CTR_W-1:0] ifetches;
  logic [CTR_W-1:0] loads;
  logic [CTR_W-1:0] stores;
  logic [CTR_W-1:0] ifetch_latency;
  logic [CTR_W-1:0] load_latency;
  logic             pending_err;

  typedef struct {
    int ife;
    int ld;
    int st;
    int ifl;
    int ldl;
    int err;
  } expT;

  expT expQ[$];

  int mIfe, mLd, mSt, mIfl, mLdl, mPendF, mPendL, mErr;
  int errors = 0;
  int checks = 0;

  // Tracker clamping is exercised on purpose, so the in-design assertion is disabled.
  vx_mem_perf_collector #(
    .PERF_CTR_BITS (CTR_W),
    .LSU_LANES     (LANES),
    .PENDING_BITS  (PEND_W),
    .ASSERT_EN     (1'b0)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .perf_en         (perf_en),
    .ifetch_req_fire (ifetch_req_fire),
    .ifetch_rsp_fire (ifetch_rsp_fire),
    .ld_req_fire     (ld_req_fire),
    .st_req_fire     (st_req_fire),
    .ld_rsp_fire     (ld_rsp_fire),
    .ifetches        (ifetches),
    .loads           (loads),
    .stores          (stores),
    .ifetch_latency  (ifetch_latency),
    .load_latency    (load_latency),
    .pending_err     (pending_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mIfe = 0; mLd = 0; mSt = 0; mIfl = 0; mLdl = 0;
    mPendF = 0; mPendL = 0; mErr = 0;
  endfunction

  function automatic void pushExpected();
    expT e;
    e.ife = mIfe; e.ld = mLd; e.st = mSt;
    e.ifl = mIfl; e.ldl = mLdl; e.err = mErr;
    expQ.push_back(e);
  endfunction

  function automatic int clampPending(input int v);
    if (v < 0) begin
      mErr = 1;
      return 0;
    end
    if (v > PEND_MAX) begin
      mErr = 1;
      return PEND_MAX;
    end
    return v;
  endfunction

  // Drives one cycle of inputs and records what the counters must hold after the edge.
  task automatic applyStimulus(input bit en, input bit iReq, input bit iRsp,
                               input logic [LANES-1:0] lReq, input logic [LANES-1:0] sReq,
                               input logic [LANES-1:0] lRsp);
    @(negedge clk);
    perf_en         = en;
    ifetch_req_fire = iReq;
    ifetch_rsp_fire = iRsp;
    ld_req_fire     = lReq;
    st_req_fire     = sReq;
    ld_rsp_fire     = lRsp;
    if (en) begin
      mIfl = (mIfl + mPendF) % CTR_MOD;
      mLdl = (mLdl + mPendL) % CTR_MOD;
      mIfe = (mIfe + int'(iReq)) % CTR_MOD;
      mLd  = (mLd + $countones(lReq)) % CTR_MOD;
      mSt  = (mSt + $countones(sReq)) % CTR_MOD;
    end
    mPendF = clampPending(mPendF + int'(iReq) - int'(iRsp));
    mPendL = clampPending(mPendL + $countones(lReq) - $countones(lRsp));
    pushExpected();
  endtask

  task automatic idle(input int n, input bit en = 1'b1);
    repeat (n) applyStimulus(en, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    perf_en = 1'b1; ifetch_req_fire = 1'b0; ifetch_rsp_fire = 1'b0;
    ld_req_fire = '0; st_req_fire = '0; ld_rsp_fire = '0;
    reset_n = 1'b0;
    modelReset();
    @(negedge clk);
    pushExpected();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compares one scoreboard entry just after every active edge that has one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        expT e;
        e = expQ.pop_front();
        checkOutput("ifetches", ifetches, e.ife);
        checkOutput("loads", loads, e.ld);
        checkOutput("stores", stores, e.st);
        checkOutput("ifetch_latency", ifetch_latency, e.ifl);
        checkOutput("load_latency", load_latency, e.ldl);
        checkOutput("pending_err", pending_err, e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b1;
    perf_en = 1'b1; ifetch_req_fire = 1'b0; ifetch_rsp_fire = 1'b0;
    ld_req_fire = '0; st_req_fire = '0; ld_rsp_fire = '0;
    modelReset();
    #2 reset_n = 1'b0;

    // Single fetch outstanding for five cycles.
    resetDut();
    idle(10);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); #2;
    checkOutput("ifetchesAfterReq", ifetches, 1);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, '0, '0);
    @(posedge clk); #2;
    checkOutput("ifetchLatency5", ifetch_latency, 5);

    // Three load lanes out for four cycles, then a burst of stores.
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, '0, '0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 4'b0111);
    @(posedge clk); #2;
    checkOutput("loads3", loads, 3);
    checkOutput("loadLatency12", load_latency, 12);
    idle(2);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0, 4'b1111, '0);
    @(posedge clk); #2;
    checkOutput("stores12", stores, 12);
    checkOutput("loadLatencyHeld", load_latency, 12);

    // Disable window while one load is in flight.
    resetDut();
    idle(18);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, '0, '0);
    idle(1);
    idle(10, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 4'b0001);
    @(posedge clk); #2;
    checkOutput("loadLatencyGated", load_latency, 4);

    // Response with nothing outstanding.
    resetDut();
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, '0, '0);
    @(posedge clk); #2;
    checkOutput("errAfterUnderflow", pending_err, 1);
    idle(3);

    // Wrap of the narrow counter, then asynchronous reset mid-cycle.
    resetDut();
    repeat (260) applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); #2;
    checkOutput("ifetchesWrap", ifetches, 4);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("asyncIfetches", ifetches, 0);
    checkOutput("asyncIfetchLatency", ifetch_latency, 0);
    checkOutput("asyncLoads", loads, 0);
    checkOutput("asyncStores", stores, 0);
    checkOutput("asyncLoadLatency", load_latency, 0);
    checkOutput("asyncErr", pending_err, 0);
    modelReset();

    // Random traffic, including clamping at both ends of the trackers.
    resetDut();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0,
                    LANES'($urandom) & LANES'($urandom),
                    LANES'($urandom),
                    LANES'($urandom) & LANES'($urandom) & LANES'($urandom));
    end
    idle(3);
    resetDut();

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_mem_perf_collector.md
# VX_mem_perf_collector

Producer of the memory-side fields of the pipeline performance bundle: `ifetches`, `loads`, `stores`, `ifetch_latency` and `load_latency`. The consumer side reads these fields; until now nothing drove them. The block sits in the core next to the fetch unit and the LSU. It observes their request and response handshakes, tracks how many transactions are outstanding, and accumulates event counts and latency-cycle sums into registered counters that the CSR and perf readout path reads.

## Interface
Parameters:
- `PERF_CTR_BITS`, default `` `PERF_CTR_BITS `` (44): width of every output counter.
- `LSU_LANES`, default 4: LSU request/response fire lanes per cycle.
- `PENDING_BITS`, default 8: width of each outstanding-transaction tracker.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `perf_en`  in  1  counter update enable; when low, output counters hold.
- `ifetch_req_fire`  in  1  I-cache request handshake (valid & ready).
- `ifetch_rsp_fire`  in  1  I-cache response handshake.
- `ld_req_fire`  in  `LSU_LANES`  per-lane load request handshake.
- `st_req_fire`  in  `LSU_LANES`  per-lane store request handshake.
- `ld_rsp_fire`  in  `LSU_LANES`  per-lane load response handshake.
- `ifetches`  out  `PERF_CTR_BITS`  fetch request count.
- `loads`  out  `PERF_CTR_BITS`  load lane-request count.
- `stores`  out  `PERF_CTR_BITS`  store lane-request count.
- `ifetch_latency`  out  `PERF_CTR_BITS`  sum of fetch cycles in flight.
- `load_latency`  out  `PERF_CTR_BITS`  sum of load cycles in flight.
- `pending_err`  out  1  sticky flag for tracker underflow or overflow.

## Operation
- Two trackers run in parallel: fetch, with 1 lane, and load, with `LSU_LANES` lanes.
  - Each tracker holds a `pending` register that counts outstanding requests.
  - `pending <= pending + popcount(req) - popcount(rsp)`.
  - `pending` updates every cycle, regardless of `perf_en`, so that the latency figures stay coherent across disable windows.
- Latency accumulation: when `perf_en`=1, each latency counter adds the current registered `pending` value every cycle.
  - A transaction that is outstanding for L cycles contributes exactly L to the sum.
- Event counters:
  - `ifetches` adds `ifetch_req_fire`.
  - `loads` adds `popcount(ld_req_fire)`.
  - `stores` adds `popcount(st_req_fire)`.
  - Event counters update only when `perf_en`=1.
- Stores are not tracked for latency; there is no store response input.
- Arithmetic:
  - Popcounts are zero-extended to the destination width.
  - Output counters wrap modulo 2^`PERF_CTR_BITS`; they do not saturate.
- Tracker boundary conditions:
  - Underflow: the computed `pending` would go below 0 (response with nothing outstanding). `pending` clamps to 0 and `pending_err` sets.
  - Overflow: the computed `pending` would exceed 2^`PENDING_BITS`-1. `pending` clamps to the maximum value and `pending_err` sets.
  - `pending_err` clears only on reset.
  - A simulation assertion fires on either condition.
- Simultaneous request and response on the same tracker in the same cycle: they cancel, and `pending` is unchanged.

## Timing
- All outputs are registered; reset value is 0 for every output and for both `pending` registers.
- Reset is asynchronous on assertion. Deassertion is synchronized upstream.
- Reset mid-operation: every counter and tracker returns to 0 immediately. Responses that arrive after reset for requests issued before it are treated as underflow (clamp to 0, set `pending_err`).
- Event latency: a fire in cycle t is visible on the corresponding counter in cycle t+1.
- Latency sum: request in cycle t, response in cycle t+L.
  - `pending` is 1 during cycles t+1 through t+L.
  - The latency counter has increased by L as of cycle t+L+1.
- `perf_en` acts in the same cycle it is sampled; there is no pipelining of the enable.

## Structure
- Counter widths come from the existing `` `PERF_CTR_BITS `` define in `VX_define.vh`.
- `LSU_LANES` is set from the LSU lane constant in `VX_gpu_pkg`; the block introduces no new typedefs.
- One sub-module, `VX_perf_pending_acc`, parameterized by lane count and widths. It contains the `pending` register, the clamp and error logic, and the latency accumulator, and is instanced twice (fetch and load).
- The top level holds the three event counters, the popcounts, and the OR of the two error flags.

## Test plan
- Reset, then a single `ifetch_req_fire` at cycle 10 and `ifetch_rsp_fire` at cycle 15 -> `ifetches`=1 at cycle 11; `ifetch_latency`=5 at cycle 16.
- `ld_req_fire`=4'b1011 in one cycle, then responses on 3 lanes 4 cycles later -> `loads`=3; `load_latency`=12; `pending` returns to 0.
- `st_req_fire`=4'b1111 for 3 consecutive cycles -> `stores`=12; `load_latency` unchanged.
- `perf_en`=0 across cycles 20-29 with one load outstanding from cycle 18 until a response at cycle 32 -> `load_latency` credits cycles 19, 30, 31 and 32, i.e. 4 (cycles 19-32 minus the 10 disabled cycles).
- Response with no pending request -> `pending` stays 0 and `pending_err`=1 from the next cycle until `reset_n` goes low.
- Preload counters near wrap using `PERF_CTR_BITS`=8: 260 `ifetch_req_fire` pulses -> `ifetches`=4. Then assert `reset_n`=0 asynchronously mid-cycle -> all outputs 0 before the next clock edge.
